// File: rtl/rfmt_control_sequencer.sv
// Control sequencer for R-format ALU instructions: fetch (T0-T2) then execute
// (T3-T5) on a single-bus datapath, with memory-wait timeout and illegal-opcode trap.
module rfmt_control_sequencer #(
  parameter int DATA_W      = 32,
  parameter int OP_W        = 5,
  parameter int NUM_ROPS    = 12,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              Clock,
  input  logic              Clear,
  input  logic              start,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] IR,
  output logic [15:0]       Rin,
  output logic [15:0]       Rout,
  output logic              PCout,
  output logic              MARin,
  output logic              IncPC,
  output logic              PCin,
  output logic              Read,
  output logic              MDRin,
  output logic              MDRout,
  output logic              IRin,
  output logic              Yin,
  output logic              ZHighin,
  output logic              ZLowin,
  output logic              ZLowout,
  output logic [OP_W-1:0]   OP,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic              timeout
);

  localparam int CNT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);
  localparam logic [OP_W:0]    NROPS     = (OP_W + 1)'(NUM_ROPS);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, ERR} state_t;

  state_t           state, state_nx;
  logic [CNT_W-1:0] wait_cnt, wait_cnt_nx;
  logic             ill_q, ill_nx, to_q, to_nx;

  logic [OP_W-1:0] opcode;
  logic [3:0]      ra, rb, rc;
  logic            unused_ir;

  assign opcode    = IR[DATA_W-1 -: OP_W];
  assign ra        = IR[DATA_W-OP_W-1 -: 4];
  assign rb        = IR[DATA_W-OP_W-5 -: 4];
  assign rc        = IR[DATA_W-OP_W-9 -: 4];
  assign unused_ir = ^IR[DATA_W-OP_W-13:0];

  always_ff @(posedge Clock or negedge Clear) begin
    if (!Clear) begin
      state    <= IDLE;
      wait_cnt <= '0;
      ill_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      ill_q    <= ill_nx;
      to_q     <= to_nx;
    end
  end

  // Wait counter is zero outside T1, so "first T1 cycle" is simply wait_cnt == 0.
  always_comb begin
    state_nx    = state;
    wait_cnt_nx = '0;
    ill_nx      = ill_q;
    to_nx       = to_q;
    case (state)
      IDLE: if (start) state_nx = T0;
      T0:   state_nx = T1;
      T1: begin
        if (mem_ready) begin
          state_nx = T2;
        end else if (wait_cnt == WAIT_LAST) begin
          state_nx = ERR;
          to_nx    = 1'b1;
        end else begin
          wait_cnt_nx = wait_cnt + CNT_W'(1);
        end
      end
      T2: begin
        if ({1'b0, opcode} < NROPS) begin
          state_nx = T3;
        end else begin
          state_nx = ERR;
          ill_nx   = 1'b1;
        end
      end
      T3:   state_nx = T4;
      T4:   state_nx = T5;
      T5:   state_nx = IDLE;
      ERR: begin
        if (start) begin
          state_nx = T0;
          ill_nx   = 1'b0;
          to_nx    = 1'b0;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    Rin     = '0;
    Rout    = '0;
    PCout   = 1'b0;
    MARin   = 1'b0;
    IncPC   = 1'b0;
    PCin    = 1'b0;
    Read    = 1'b0;
    MDRin   = 1'b0;
    MDRout  = 1'b0;
    IRin    = 1'b0;
    Yin     = 1'b0;
    ZHighin = 1'b0;
    ZLowin  = 1'b0;
    ZLowout = 1'b0;
    OP      = '0;
    busy    = 1'b0;
    done    = 1'b0;
    illegal = ill_q;
    timeout = to_q;
    case (state)
      T0: begin
        busy  = 1'b1;
        PCout = 1'b1;
        MARin = 1'b1;
        IncPC = 1'b1;
      end
      T1: begin
        busy  = 1'b1;
        Read  = 1'b1;
        MDRin = 1'b1;
        PCin  = (wait_cnt == '0);
      end
      T2: begin
        busy   = 1'b1;
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        busy = 1'b1;
        Rout = 16'h0001 << rb;
        Yin  = 1'b1;
      end
      T4: begin
        busy    = 1'b1;
        Rout    = 16'h0001 << rc;
        ZHighin = 1'b1;
        ZLowin  = 1'b1;
        OP      = opcode;
      end
      T5: begin
        busy    = 1'b1;
        ZLowout = 1'b1;
        done    = 1'b1;
        // R0 is hard-wired; its write enable never asserts.
        if (ra != 4'd0) Rin = 16'h0001 << ra;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rfmt_control_sequencer.sv
// Directed bench for rfmt_control_sequencer: per-cycle comparison against a
// phase-level model of the instruction sequence, plus literal spot checks.
module tb_rfmt_control_sequencer;

  localparam int MEM_TIMEOUT = 15;
  localparam int NUM_ROPS    = 12;

  logic        Clock, Clear, start, mem_ready;
  logic [31:0] ir_in;
  logic [15:0] Rin, Rout;
  logic        PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin;
  logic        Yin, ZHighin, ZLowin, ZLowout;
  logic [4:0]  OP;
  logic        busy, done, illegal, timeout;

  typedef struct packed {
    logic [15:0] rin;
    logic [15:0] rout;
    logic pcout, marin, incpc, pcin, read, mdrin, mdrout, irin;
    logic yin, zhighin, zlowin, zlowout;
    logic [4:0] op;
    logic busy, done, illegal, timeout;
  } outv;

  outv dut_v, exp;
  bit  exp_valid;
  int  total, bad, cyc;
  int  t0_cyc, lat_exp;
  logic [15:0] snap_y, snap_z, snap_rin;
  logic [4:0]  snap_op;
  int  n_yin, n_zlowin, n_rin, n_incpc, n_pcin, n_read, n_done;

  rfmt_control_sequencer #(.DATA_W(32), .OP_W(5), .NUM_ROPS(NUM_ROPS), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .Clock(Clock), .Clear(Clear), .start(start), .mem_ready(mem_ready), .IR(ir_in),
    .Rin(Rin), .Rout(Rout), .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .PCin(PCin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin), .Yin(Yin),
    .ZHighin(ZHighin), .ZLowin(ZLowin), .ZLowout(ZLowout), .OP(OP),
    .busy(busy), .done(done), .illegal(illegal), .timeout(timeout)
  );

  assign dut_v = {Rin, Rout, PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin,
                  Yin, ZHighin, ZLowin, ZLowout, OP, busy, done, illegal, timeout};

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge Clock);
      cyc = cyc + 1;
    end
  end

  // Phase-level model: what each step of the instruction must show on the outputs.
  function automatic outv o_idle();
    outv o;
    o = '0;
    return o;
  endfunction
  function automatic outv o_t0();
    outv o;
    o = '0; o.pcout = 1; o.marin = 1; o.incpc = 1; o.busy = 1;
    return o;
  endfunction
  function automatic outv o_t1(input bit first);
    outv o;
    o = '0; o.read = 1; o.mdrin = 1; o.pcin = first; o.busy = 1;
    return o;
  endfunction
  function automatic outv o_t2();
    outv o;
    o = '0; o.mdrout = 1; o.irin = 1; o.busy = 1;
    return o;
  endfunction
  function automatic outv o_t3(input logic [31:0] ir);
    outv o;
    o = '0; o.rout = 16'h1 << ir[22:19]; o.yin = 1; o.busy = 1;
    return o;
  endfunction
  function automatic outv o_t4(input logic [31:0] ir);
    outv o;
    o = '0; o.rout = 16'h1 << ir[18:15]; o.zhighin = 1; o.zlowin = 1;
    o.op = ir[31:27]; o.busy = 1;
    return o;
  endfunction
  function automatic outv o_t5(input logic [31:0] ir);
    outv o;
    o = '0; o.zlowout = 1; o.done = 1; o.busy = 1;
    o.rin = (ir[26:23] == 4'd0) ? 16'h0 : (16'h1 << ir[26:23]);
    return o;
  endfunction
  function automatic outv o_err(input bit ill, input bit to);
    outv o;
    o = '0; o.illegal = ill; o.timeout = to;
    return o;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // One clock: after the edge the outputs must equal e; then drive inputs for the next edge.
  task automatic cycle(input outv e, input logic st, input logic mr);
    @(posedge Clock);
    #1;
    exp = e;
    start = st;
    mem_ready = mr;
  endtask

  // waits < 0 means memory never answers. poke drives start while busy.
  task automatic run(input logic [31:0] ir, input int waits, input outv pre, input bit poke);
    int nt1;
    ir_in = ir;
    cycle(pre, 1'b1, 1'b0);
    cycle(o_t0(), 1'b0, 1'b0);
    t0_cyc = cyc;
    lat_exp = 6 + waits;
    nt1 = (waits < 0) ? MEM_TIMEOUT : waits + 1;
    for (int w = 0; w < nt1; w++)
      cycle(o_t1(w == 0), poke && (w == 0), (waits >= 0) && (w == waits));
    if (waits < 0) begin
      cycle(o_err(1'b0, 1'b1), 1'b0, 1'b0);
      return;
    end
    cycle(o_t2(), 1'b0, 1'b0);
    if (int'(ir[31:27]) >= NUM_ROPS) begin
      cycle(o_err(1'b1, 1'b0), 1'b0, 1'b0);
      return;
    end
    cycle(o_t3(ir), poke, 1'b0);
    cycle(o_t4(ir), 1'b0, 1'b0);
    cycle(o_t5(ir), poke, 1'b0);
  endtask

  initial begin
    forever begin
      @(negedge Clock);
      if (exp_valid) begin
        total++;
        if (dut_v !== exp) begin
          bad++;
          $display("FAIL outputs cyc=%0d got=%h want=%h", cyc, dut_v, exp);
        end
      end
      total++;
      if ((int'(Rout != 16'h0) + int'(PCout) + int'(MDRout) + int'(ZLowout)) > 1 ||
          $countones(Rin) > 1 || $countones(Rout) > 1) begin
        bad++;
        $display("FAIL bus_exclusive cyc=%0d got Rin=%h Rout=%h PCout=%b MDRout=%b ZLowout=%b want at most one driver",
                 cyc, Rin, Rout, PCout, MDRout, ZLowout);
      end
      if (Yin) snap_y = Rout;
      if (ZLowin) begin
        snap_z = Rout;
        snap_op = OP;
      end
      n_yin    += int'(Yin);
      n_zlowin += int'(ZLowin);
      n_rin    += int'(Rin != 16'h0);
      n_incpc  += int'(IncPC);
      n_pcin   += int'(PCin);
      n_read   += int'(Read);
      if (done) begin
        snap_rin = Rin;
        n_done++;
        total++;
        if (cyc - t0_cyc + 1 != lat_exp) begin
          bad++;
          $display("FAIL latency got=%0d want=%0d", cyc - t0_cyc + 1, lat_exp);
        end
      end
    end
  end

  initial begin
    int b_inc, b_pcin, b_read, b_yin, b_zl, b_rin, b_done;
    total = 0; bad = 0; exp_valid = 0;
    n_yin = 0; n_zlowin = 0; n_rin = 0; n_incpc = 0; n_pcin = 0; n_read = 0; n_done = 0;
    snap_y = '0; snap_z = '0; snap_rin = '0; snap_op = '0; t0_cyc = 0; lat_exp = 0;
    Clear = 1'b0; start = 1'b1; mem_ready = 1'b1; ir_in = 32'h28918000;
    exp = o_idle();
    #1;
    exp_valid = 1;
    chk("reset_outputs", 64'(dut_v), 64'h0);
    repeat (2) @(posedge Clock);
    #1;
    chk("reset_hold", 64'(dut_v), 64'h0);
    Clear = 1'b1; start = 1'b0;
    cycle(o_idle(), 1'b0, 1'b0);
    cycle(o_idle(), 1'b0, 1'b0);

    // Basic instruction, memory ready at once.
    run(32'h28918000, 0, o_idle(), 1'b0);
    cycle(o_idle(), 1'b0, 1'b0);
    chk("t3_rout", 64'(snap_y), 64'h0004);
    chk("t4_rout", 64'(snap_z), 64'h0008);
    chk("t4_op",   64'(snap_op), 64'd5);
    chk("t5_rin",  64'(snap_rin), 64'h0002);
    chk("done_count1", 64'(n_done), 64'd1);

    // Three memory wait cycles.
    b_inc = n_incpc; b_pcin = n_pcin; b_read = n_read;
    run(32'h28918000, 3, o_idle(), 1'b0);
    cycle(o_idle(), 1'b0, 1'b0);
    chk("incpc_once", 64'(n_incpc - b_inc), 64'd1);
    chk("pcin_once",  64'(n_pcin - b_pcin), 64'd1);
    chk("t1_cycles",  64'(n_read - b_read), 64'd4);

    // Longest wait that still completes.
    run(32'h28918000, MEM_TIMEOUT - 1, o_idle(), 1'b0);
    cycle(o_idle(), 1'b0, 1'b0);

    // Memory never answers: timeout trap, then restart clears the flag.
    run(32'h28918000, -1, o_idle(), 1'b0);
    repeat (3) cycle(o_err(1'b0, 1'b1), 1'b0, 1'b1);
    run(32'h28918000, 0, o_err(1'b0, 1'b1), 1'b0);
    cycle(o_idle(), 1'b0, 1'b0);

    // Opcode == NUM_ROPS traps; opcode NUM_ROPS-1 runs normally from ERR.
    b_yin = n_yin; b_zl = n_zlowin; b_rin = n_rin;
    run(32'h60918000, 0, o_idle(), 1'b0);
    repeat (2) cycle(o_err(1'b1, 1'b0), 1'b0, 1'b0);
    chk("illegal_no_yin",    64'(n_yin - b_yin), 64'd0);
    chk("illegal_no_zlowin", 64'(n_zlowin - b_zl), 64'd0);
    chk("illegal_no_rin",    64'(n_rin - b_rin), 64'd0);
    run(32'h58918000, 0, o_err(1'b1, 1'b0), 1'b0);
    cycle(o_idle(), 1'b0, 1'b0);
    chk("op11_z_op", 64'(snap_op), 64'd11);

    // Ra = 0 with start poked while busy.
    b_done = n_done;
    run(32'h182B8000, 0, o_idle(), 1'b1);
    repeat (2) cycle(o_idle(), 1'b0, 1'b0);
    chk("ra0_rin",  64'(snap_rin), 64'h0000);
    chk("ra0_done", 64'(n_done - b_done), 64'd1);
    chk("ra0_rout_t3", 64'(snap_y), 64'h0020);

    // Asynchronous clear in the middle of T4.
    ir_in = 32'h28918000;
    cycle(o_idle(), 1'b1, 1'b0);
    cycle(o_t0(), 1'b0, 1'b0);
    cycle(o_t1(1'b1), 1'b0, 1'b1);
    cycle(o_t2(), 1'b0, 1'b0);
    cycle(o_t3(ir_in), 1'b0, 1'b0);
    cycle(o_t4(ir_in), 1'b0, 1'b0);
    #2;
    Clear = 1'b0;
    exp = o_idle();
    #1;
    chk("async_clear_t4", 64'(dut_v), 64'h0);
    cycle(o_idle(), 1'b1, 1'b0);
    cycle(o_idle(), 1'b0, 1'b0);
    Clear = 1'b1;
    cycle(o_idle(), 1'b0, 1'b0);
    run(32'h28918000, 0, o_idle(), 1'b0);
    cycle(o_idle(), 1'b0, 1'b0);
    chk("after_clear_rin", 64'(snap_rin), 64'h0002);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rfmt_control_sequencer.md
RFMT_CONTROL_SEQUENCER -- requirements
Module: rfmt_control_sequencer

Parameters
REQ-001 The block SHALL have parameter DATA_W, default 32, giving the instruction and IR width; legal values are 32 or more.
REQ-002 The block SHALL have parameter OP_W, default 5, giving the opcode field width, taken as IR[DATA_W-1 -: OP_W].
REQ-003 The block SHALL have parameter NUM_ROPS, default 12; opcodes below NUM_ROPS are legal R-format ALU ops.
REQ-004 The block SHALL have parameter MEM_TIMEOUT, default 15, giving the maximum number of T1 wait cycles before the fetch is aborted.

Interface
REQ-005 Clock  in  1  sole clock; all state changes on its rising edge.
REQ-006 Clear  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  request to run one instruction; sampled in IDLE only.
REQ-008 mem_ready  in  1  memory read data valid.
REQ-009 IR  in  DATA_W  instruction register contents; Ra=IR[DATA_W-OP_W-1 -: 4], Rb and Rc the next two 4-bit fields.
REQ-010 Rin, Rout  out  16  one-hot register-file load and drive enables.
REQ-011 PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, ZHighin, ZLowin, ZLowout  out  1 each  datapath strobes.
REQ-012 OP  out  OP_W  ALU operation select.
REQ-013 busy, done, illegal, timeout  out  1 each  status outputs.

Function
REQ-014 The FSM states SHALL be IDLE, T0, T1, T2, T3, T4, T5 and ERR, with all outputs decoded from registered state (Moore).
REQ-015 In IDLE with start=1, the FSM SHALL go to T0 at the next edge; with start=0 it SHALL stay in IDLE.
REQ-016 T0 SHALL assert PCout, MARin and IncPC, then go to T1 unconditionally.
REQ-017 T1 SHALL assert Read and MDRin.
REQ-018 T1 SHALL assert PCin on its first cycle only.
REQ-019 T1 SHALL stay in T1 while mem_ready=0, counting wait cycles in a counter that is cleared on T1 entry.
REQ-020 In T1, mem_ready=1 SHALL take the FSM to T2.
REQ-021 In T1, a wait count reaching MEM_TIMEOUT with mem_ready=0 SHALL take the FSM to ERR with timeout=1.
REQ-022 T2 SHALL assert MDRout and IRin; the FSM SHALL then go to T3 if the opcode is below NUM_ROPS, else to ERR with illegal=1.
REQ-023 T3 SHALL assert Rout[Rb] and Yin.
REQ-024 T4 SHALL assert Rout[Rc], ZHighin and ZLowin, with OP equal to the opcode.
REQ-025 OP SHALL be 0 in every state other than T4.
REQ-026 T5 SHALL assert ZLowout and Rin[Ra], pulse done for one cycle, and then go to IDLE.
REQ-027 When Ra=0, Rin SHALL remain all-zero in T5 (R0 write suppressed) and done SHALL still pulse.
REQ-028 ERR SHALL hold its flag and keep all strobes at 0 until start=1, which SHALL clear the flags and go to T0.
REQ-029 busy SHALL be 1 in T0..T5 and 0 in IDLE and ERR.
REQ-030 Instruction latency SHALL be 6+W cycles from the start-sampling edge to the done pulse, where W is the number of T1 wait cycles.
REQ-031 No two of Rout, PCout, MDRout and ZLowout SHALL be asserted in the same cycle (single bus driver).
REQ-032 Rin and Rout SHALL each have at most one bit set.
REQ-033 A start asserted while busy=1 SHALL be ignored.

Reset
REQ-034 Clear=0 SHALL force IDLE asynchronously, from any state and mid-instruction.
REQ-035 During and after reset, all strobes, Rin, Rout, OP, busy, done, illegal, timeout and the wait counter SHALL be 0.
REQ-036 After Clear rises, the first state change SHALL occur on a rising edge with start=1.

Verification
REQ-037 IR=0x28918000, start pulse, mem_ready=1 in first T1 -> T3 Rout=0x0004, Yin; T4 Rout=0x0008, OP=5; T5 Rin=0x0002, done one cycle; latency 6.
REQ-038 Same IR, mem_ready delayed 3 cycles -> T1 held 4 cycles with PCin only in the first; done at cycle 9; no double IncPC.
REQ-039 mem_ready held 0 -> after MEM_TIMEOUT wait cycles, ERR with timeout=1 and busy=0; next start clears timeout and restarts at T0.
REQ-040 Opcode=NUM_ROPS -> ERR after T2 with illegal=1, and no Yin, ZLowin or Rin ever asserted.
REQ-041 Clear=0 asserted mid-T4 -> all outputs 0 immediately, before the next edge; after release, FSM in IDLE; start runs a clean instruction.
REQ-042 Ra=0 -> Rin=0 in T5 and done=1; start asserted while busy -> no effect on the state sequence; bus-exclusivity assertion holds throughout.
